// File: rtl/seq_det_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : seq_det_scheduler
//  Description : Round-robin time-shared overlapping pattern detector with a
//                saved history/fill/match-count context per channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_scheduler #(
    parameter int              NCH     = 4,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011,
    parameter int              CW      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH-1:0]           req_bit,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH-1:0]           clr_ch,
    output logic                     det_valid,
    output logic [$clog2(NCH)-1:0]   det_ch,
    output logic                     det_hit,
    input  logic [$clog2(NCH)-1:0]   rd_ch,
    output logic [CW-1:0]            rd_cnt
);

    localparam int               CHW        = $clog2(NCH);
    localparam int               FW         = $clog2(PLEN);
    localparam logic [FW-1:0]    c_fill_max = FW'(PLEN - 1);
    localparam logic [CHW:0]     c_nch      = (CHW + 1)'(NCH);

    logic [PLEN-2:0] r_hist [NCH];
    logic [FW-1:0]   r_fill [NCH];
    logic [CW-1:0]   r_cnt  [NCH];
    logic [CHW-1:0]  r_rr;

    logic [NCH-1:0]  w_elig;
    logic [NCH-1:0]  w_grant;
    logic [CHW-1:0]  w_gidx;
    logic [CHW-1:0]  w_pos;
    logic [CHW:0]    w_sum;
    logic            w_xfer;
    logic            w_bit;
    logic [PLEN-1:0] w_cat;
    logic            w_hit;

    assign w_elig = req_valid & ~clr_ch;

    // Walk the channels starting at the pointer; the first eligible one wins.
    always_comb begin
        w_xfer = 1'b0;
        w_gidx = '0;
        w_pos  = '0;
        w_sum  = '0;
        for (int k = 0; k < NCH; k++) begin
            w_sum = {1'b0, r_rr} + (CHW + 1)'(k);
            if (w_sum >= c_nch) begin
                w_sum = w_sum - c_nch;
            end
            w_pos = w_sum[CHW-1:0];
            if (!w_xfer && w_elig[w_pos]) begin
                w_xfer = 1'b1;
                w_gidx = w_pos;
            end
        end
        w_grant = w_xfer ? (NCH'(1) << w_gidx) : '0;
    end

    assign req_ready = w_grant;

    assign w_bit = req_bit[w_gidx];
    assign w_cat = {r_hist[w_gidx], w_bit};
    // Hit needs a full window: PLEN-1 saved bits plus the incoming one.
    assign w_hit = (r_fill[w_gidx] == c_fill_max) && (w_cat == PATTERN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr      <= '0;
            det_valid <= 1'b0;
            det_ch    <= '0;
            det_hit   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_hist[i] <= '0;
                r_fill[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            det_valid <= w_xfer;
            det_hit   <= w_xfer & w_hit;
            if (w_xfer) begin
                det_ch <= w_gidx;
                r_rr   <= (w_gidx == CHW'(NCH - 1)) ? '0 : w_gidx + CHW'(1);
            end
            for (int i = 0; i < NCH; i++) begin
                if (clr_ch[i]) begin
                    r_hist[i] <= '0;
                    r_fill[i] <= '0;
                    r_cnt[i]  <= '0;
                end else if (w_xfer && (w_gidx == CHW'(i))) begin
                    r_hist[i] <= w_cat[PLEN-2:0];
                    if (r_fill[i] != c_fill_max) begin
                        r_fill[i] <= r_fill[i] + FW'(1);
                    end
                    if (w_hit && (r_cnt[i] != '1)) begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign rd_cnt = ({1'b0, rd_ch} < c_nch) ? r_cnt[rd_ch] : '0;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seq_det_scheduler
//  Description : Scoreboard bench for seq_det_scheduler with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_scheduler;

    localparam int              NCH     = 4;
    localparam int              PLEN    = 4;
    localparam logic [PLEN-1:0] PATTERN = 4'b1011;
    localparam int              CW      = 2;
    localparam int              MAXC    = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] req_valid = '0;
    logic [NCH-1:0] req_bit   = '0;
    logic [NCH-1:0] req_ready;
    logic [NCH-1:0] clr_ch    = '0;
    logic           det_valid;
    logic [1:0]     det_ch;
    logic           det_hit;
    logic [1:0]     rd_ch     = '0;
    logic [CW-1:0]  rd_cnt;

    seq_det_scheduler #(
        .NCH(NCH), .PLEN(PLEN), .PATTERN(PATTERN), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_bit(req_bit), .req_ready(req_ready),
        .clr_ch(clr_ch),
        .det_valid(det_valid), .det_ch(det_ch), .det_hit(det_hit),
        .rd_ch(rd_ch), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int hit;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    // Reference model: last PLEN bits seen per channel, bit count, hit count.
    logic [PLEN-1:0] m_sh   [NCH];
    int              m_seen [NCH];
    int              m_cnt  [NCH];
    int              m_ptr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_sh[i]   = '0;
            m_seen[i] = 0;
            m_cnt[i]  = 0;
        end
        m_ptr = 0;
        q.delete();
    endtask

    // Apply one cycle of inputs, check the combinational outputs, advance the model.
    task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                         input logic [NCH-1:0] clr, input logic [1:0] rd);
        int            g;
        int            c;
        int            hit;
        logic [NCH-1:0] exp_rdy;
        exp_t          e;
        req_valid = v;
        req_bit   = b;
        clr_ch    = clr;
        rd_ch     = rd;
        #2;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            c = (m_ptr + k) % NCH;
            if (g < 0 && v[c] && !clr[c]) g = c;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        chk("rd_cnt", int'(rd_cnt), m_cnt[rd]);
        if (g >= 0) begin
            m_sh[g] = {m_sh[g][PLEN-2:0], b[g]};
            m_seen[g]++;
            hit = (m_seen[g] >= PLEN && m_sh[g] == PATTERN) ? 1 : 0;
            if (hit == 1 && m_cnt[g] < MAXC) m_cnt[g]++;
            e.ch  = g;
            e.hit = hit;
            e.cyc = cyc;
            q.push_back(e);
            m_ptr = (g + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) begin
            if (clr[i]) begin
                m_sh[i]   = '0;
                m_seen[i] = 0;
                m_cnt[i]  = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive('0, '0, '0, 2'd0);
        step();
    endtask

    task automatic send0(input logic [15:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            drive(4'b0001, {3'b000, s[i]}, '0, 2'd0);
            step();
        end
    endtask

    task automatic check_reset_state();
        chk("rst_det_valid", int'(det_valid), 0);
        chk("rst_det_hit", int'(det_hit), 0);
        chk("rst_det_ch", int'(det_ch), 0);
        for (int i = 0; i < NCH; i++) begin
            rd_ch = 2'(i);
            #1;
            chk("rst_rd_cnt", int'(rd_cnt), 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        req_valid = '0;
        clr_ch    = '0;
        rst       = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        step();
        rst = 1'b0;
    endtask

    // Monitor: every presented detection result is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (det_valid) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL det_spurious: det_valid=1 with ch %0d, none expected", det_ch);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("det_ch", int'(det_ch), e.ch);
                    chk("det_hit", int'(det_hit), e.hit);
                    chk("det_latency", cyc, e.cyc + 1);
                end
            end else begin
                chk("det_hit_idle", int'(det_hit), 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] s;
        logic [NCH-1:0] rv, rb, rc;
        model_reset();
        #1;
        check_reset_state();
        step();
        rst = 1'b0;

        // lone requester, overlapping hits on bits 4 and 7
        s = 16'b1011011;
        send0(s, 7);
        drive('0, '0, '0, 2'd0);
        chk("t1_cnt", int'(rd_cnt), 2);
        step();

        // two continuous requesters alternate
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b0101, 4'($urandom), '0, 2'($urandom_range(0, 3)));
            step();
        end

        // interleaved channels 0 and 1
        do_reset();
        s = 16'b1011;
        for (int i = 3; i >= 0; i--) begin
            drive(4'b0001, {3'b000, s[i]}, '0, 2'd0);
            step();
            drive(4'b0010, 4'b0000, '0, 2'd1);
            step();
        end
        drive('0, '0, '0, 2'd1);
        chk("t3_ch1_cnt", int'(rd_cnt), 0);
        step();

        // clear with a pending request is not granted and wipes the context
        do_reset();
        s = 16'b101;
        send0(s, 3);
        drive(4'b0001, 4'b0001, 4'b0001, 2'd0);
        step();
        s = 16'b1;
        send0(s, 1);
        drive('0, '0, '0, 2'd0);
        chk("t4_cnt", int'(rd_cnt), 0);
        step();

        // counter saturation: five hits on a 2-bit counter
        do_reset();
        s = 16'b1011011011011011;
        send0(s, 16);
        drive('0, '0, '0, 2'd0);
        chk("t5_sat_cnt", int'(rd_cnt), MAXC);
        step();

        // asynchronous reset drops the in-flight result and the history
        do_reset();
        s = 16'b10;
        send0(s, 2);
        drive(4'b0001, 4'b0001, '0, 2'd0);
        #1;
        rst = 1'b1;
        #1;
        check_reset_state();
        model_reset();
        step();
        rst = 1'b0;
        s = 16'b1;
        send0(s, 1);
        idle();

        // randomized mixed traffic with occasional clears
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rv = 4'($urandom);
            rb = 4'($urandom);
            rc = '0;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 31) == 0) rc[i] = 1'b1;
            end
            drive(rv, rb, rc, 2'($urandom_range(0, 3)));
            step();
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        chk("queue_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
